// File: rtl/stopwatch_pkg.sv
// Shared types, seven-segment constants and BCD helpers for the stopwatch core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam int NUM_DIGITS = 4;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Increment a two-digit BCD value, wrapping to zero once it reaches max_val.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input int max_val);
    bcd2_t r;
    if (int'(v.tens) * 10 + int'(v.ones) >= max_val) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_DIGIT[0];
      4'd1:    s = SEG_DIGIT[1];
      4'd2:    s = SEG_DIGIT[2];
      4'd3:    s = SEG_DIGIT[3];
      4'd4:    s = SEG_DIGIT[4];
      4'd5:    s = SEG_DIGIT[5];
      4'd6:    s = SEG_DIGIT[6];
      4'd7:    s = SEG_DIGIT[7];
      4'd8:    s = SEG_DIGIT[8];
      4'd9:    s = SEG_DIGIT[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_core_sync_edge.sv
// Synchronizer chain plus rising-edge detector producing a one-cycle tick.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES:0] chain;
  logic [SYNC_STAGES:0] primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= '0;
      primed <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-1:0], d};
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Mask edges until the whole chain holds real samples, so a level that is
  // already high when reset releases never looks like a new edge.
  assign rise = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES] & primed[SYNC_STAGES];

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss BCD stopwatch with pause/adjust modes and 4-digit multiplexed display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       counter_clk,
  input  logic       adj_clk,
  input  logic       disp_clk,
  input  logic       blink_clk,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic cnt_tick, adj_tick, disp_tick, blink_tick, pause_tick;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cnt   (.clk(clk), .rst(rst), .d(counter_clk), .rise(cnt_tick));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_adj   (.clk(clk), .rst(rst), .d(adj_clk),     .rise(adj_tick));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_disp  (.clk(clk), .rst(rst), .d(disp_clk),    .rise(disp_tick));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_blink (.clk(clk), .rst(rst), .d(blink_clk),   .rise(blink_tick));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pause (.clk(clk), .rst(rst), .d(pause_btn),   .rise(pause_tick));

  bcd2_t      min_r, sec_r;
  logic       paused, blink_phase;
  digit_idx_t digit_idx;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  bcd_t       cur_digit;
  logic       blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_r       <= '0;
      sec_r       <= '0;
      paused      <= 1'b0;
      blink_phase <= 1'b1;
      digit_idx   <= '0;
      an          <= 4'b1110;
      seg         <= SEG_DIGIT[0];
    end else begin
      // Ticks are qualified by the pre-toggle paused value.
      if (!paused) begin
        if (!adj && cnt_tick) begin
          if (sec_r == 8'h59) min_r <= bcd2_inc(min_r, MAX_MIN);
          sec_r <= bcd2_inc(sec_r, 59);
        end else if (adj && adj_tick) begin
          if (sel) sec_r <= bcd2_inc(sec_r, 59);
          else     min_r <= bcd2_inc(min_r, MAX_MIN);
        end
      end
      if (pause_tick) paused      <= ~paused;
      if (blink_tick) blink_phase <= ~blink_phase;
      if (disp_tick)  digit_idx   <= digit_idx + 2'd1;
      an  <= an_next;
      seg <= seg_next;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    case (digit_idx)
      2'd3:    cur_digit = min_r.tens;
      2'd2:    cur_digit = min_r.ones;
      2'd1:    cur_digit = sec_r.tens;
      default: cur_digit = sec_r.ones;
    endcase
    // Upper pair is minutes, lower pair is seconds.
    blank    = adj & ~blink_phase & (sel ? ~digit_idx[1] : digit_idx[1]);
    an_next  = ~(4'b0001 << digit_idx);
    seg_next = blank ? SEG_BLANK : seg_decode(cur_digit);
  end

  assign min_bcd = min_r;
  assign sec_bcd = sec_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, corner sequences, random vs model.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] lv = '0;  // {pause_btn, blink_clk, disp_clk, adj_clk, counter_clk}
  logic adj = 1'b0;
  logic sel = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic [3:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.SYNC_STAGES(2), .MAX_MIN(59)) dut (
    .clk(clk), .rst(rst),
    .counter_clk(lv[0]), .adj_clk(lv[1]), .disp_clk(lv[2]), .blink_clk(lv[3]),
    .pause_btn(lv[4]), .adj(adj), .sel(sel),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .an(an), .seg(seg)
  );

  typedef struct {
    logic [4:0] lv;
    logic       adj;
    logic       sel;
    logic [7:0] emin;
    logic [7:0] esec;
    logic [3:0] ean;
  } vec_t;

  vec_t tbl [18];

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: plain integers, event-level behaviour.
  int m_min, m_sec, m_idx;
  bit m_paused, m_blink;
  logic [4:0] m_lv;

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; lv = '0; adj = 1'b0; sel = 1'b0;
    hold(2);
    rst = 1'b0;
    hold(5);
  endtask

  task automatic pulse(input int b);
    lv[b] = 1'b1; hold(4);
    lv[b] = 1'b0; hold(4);
  endtask

  task automatic pulses(input int b, input int n);
    for (int i = 0; i < n; i++) pulse(b);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_idx = 0; m_paused = 0; m_blink = 1; m_lv = '0;
  endtask

  task automatic model_apply(input logic [4:0] nlv, input logic nadj, input logic nsel);
    logic [4:0] r;
    r = nlv & ~m_lv;
    if (!m_paused) begin
      if (!nadj && r[0]) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = (m_min == 59) ? 0 : m_min + 1;
        end
      end else if (nadj && r[1]) begin
        if (nsel) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        else      m_min = (m_min == 59) ? 0 : m_min + 1;
      end
    end
    if (r[4]) m_paused = !m_paused;
    if (r[3]) m_blink = !m_blink;
    if (r[2]) m_idx = (m_idx + 1) % 4;
    m_lv = nlv;
  endtask

  function automatic logic [6:0] model_seg(input logic madj, input logic msel);
    int d;
    bit upper;
    upper = (m_idx >= 2);
    case (m_idx)
      3: d = m_min / 10;
      2: d = m_min % 10;
      1: d = m_sec / 10;
      default: d = m_sec % 10;
    endcase
    if (madj && !m_blink && (msel ? !upper : upper)) return 7'h7F;
    return seg_tab[d];
  endfunction

  initial begin
    tbl[0]  = '{5'b00000, 0, 0, 8'h00, 8'h00, 4'b1110};
    tbl[1]  = '{5'b00100, 0, 0, 8'h00, 8'h00, 4'b1101};
    tbl[2]  = '{5'b00000, 0, 0, 8'h00, 8'h00, 4'b1101};
    tbl[3]  = '{5'b00100, 0, 0, 8'h00, 8'h00, 4'b1011};
    tbl[4]  = '{5'b00000, 0, 0, 8'h00, 8'h00, 4'b1011};
    tbl[5]  = '{5'b00100, 0, 0, 8'h00, 8'h00, 4'b0111};
    tbl[6]  = '{5'b00000, 0, 0, 8'h00, 8'h00, 4'b0111};
    tbl[7]  = '{5'b00100, 0, 0, 8'h00, 8'h00, 4'b1110};
    tbl[8]  = '{5'b00001, 0, 0, 8'h00, 8'h01, 4'b1110};
    tbl[9]  = '{5'b00001, 0, 0, 8'h00, 8'h01, 4'b1110};
    tbl[10] = '{5'b00010, 0, 0, 8'h00, 8'h01, 4'b1110};
    tbl[11] = '{5'b00001, 0, 0, 8'h00, 8'h02, 4'b1110};
    tbl[12] = '{5'b00000, 0, 0, 8'h00, 8'h02, 4'b1110};
    tbl[13] = '{5'b00010, 1, 1, 8'h00, 8'h03, 4'b1110};
    tbl[14] = '{5'b00000, 1, 1, 8'h00, 8'h03, 4'b1110};
    tbl[15] = '{5'b00010, 1, 0, 8'h01, 8'h03, 4'b1110};
    tbl[16] = '{5'b00001, 1, 0, 8'h01, 8'h03, 4'b1110};
    tbl[17] = '{5'b00000, 0, 0, 8'h01, 8'h03, 4'b1110};

    hold(1);
    do_reset();
    chk("reset_min", min_bcd, 8'h00);
    chk("reset_sec", sec_bcd, 8'h00);
    chk("reset_an", {4'h0, an}, 8'h0E);
    chk("reset_seg", {1'b0, seg}, 8'h40);

    for (int i = 0; i < 18; i++) begin
      lv = tbl[i].lv; adj = tbl[i].adj; sel = tbl[i].sel;
      hold(5);
      chk($sformatf("vec%0d_min", i), min_bcd, tbl[i].emin);
      chk($sformatf("vec%0d_sec", i), sec_bcd, tbl[i].esec);
      chk($sformatf("vec%0d_an", i), {4'h0, an}, {4'h0, tbl[i].ean});
    end

    // Latency: rise seen at edge k, count visible after edge k+2; held level counts once.
    do_reset();
    lv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("lat_k", sec_bcd, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("lat_k1", sec_bcd, 8'h00);
    @(posedge clk); #1;
    chk("lat_k2", sec_bcd, 8'h01);
    hold(8);
    chk("lat_held", sec_bcd, 8'h01);
    lv[0] = 1'b0; hold(4);

    // Run and wrap.
    do_reset();
    pulses(0, 60);
    chk("run60_sec", sec_bcd, 8'h00);
    chk("run60_min", min_bcd, 8'h01);
    do_reset();
    adj = 1'b1; sel = 1'b0; pulses(1, 59);
    sel = 1'b1; pulses(1, 59);
    chk("pre_min", min_bcd, 8'h59);
    chk("pre_sec", sec_bcd, 8'h59);
    adj = 1'b0; pulse(0);
    chk("wrap_min", min_bcd, 8'h00);
    chk("wrap_sec", sec_bcd, 8'h00);

    // Pause edge coincident with a counter edge: that tick still counts.
    do_reset();
    pulses(0, 4);
    lv[0] = 1'b1; lv[4] = 1'b1; hold(4);
    lv = '0; hold(4);
    chk("pause_coinc", sec_bcd, 8'h05);
    pulses(0, 3);
    chk("pause_hold", sec_bcd, 8'h05);
    adj = 1'b1; sel = 1'b1; pulse(1); adj = 1'b0;
    chk("pause_adj", sec_bcd, 8'h05);
    pulse(4); pulse(0);
    chk("resume", sec_bcd, 8'h06);

    // Adjust wraps without carry; counter edges ignored.
    do_reset();
    adj = 1'b1; sel = 1'b1; pulses(1, 59);
    chk("adj_s59", sec_bcd, 8'h59);
    pulse(1);
    chk("adj_swrap_sec", sec_bcd, 8'h00);
    chk("adj_swrap_min", min_bcd, 8'h00);
    sel = 1'b0; pulses(1, 59);
    chk("adj_m59", min_bcd, 8'h59);
    pulse(0);
    chk("adj_cnt_ign", min_bcd, 8'h59);
    chk("adj_cnt_ign_s", sec_bcd, 8'h00);
    pulse(1);
    chk("adj_mwrap", min_bcd, 8'h00);

    // Blink of the selected pair.
    do_reset();
    adj = 1'b1; sel = 1'b0; hold(3);
    chk("blink_on", {1'b0, seg}, 8'h40);
    pulse(3);
    pulse(2);
    chk("blink_idx1_an", {4'h0, an}, 8'h0D);
    chk("blink_idx1_seg", {1'b0, seg}, 8'h40);
    pulse(2);
    chk("blink_idx2_an", {4'h0, an}, 8'h0B);
    chk("blink_idx2_seg", {1'b0, seg}, 8'h7F);
    pulse(2);
    chk("blink_idx3_an", {4'h0, an}, 8'h07);
    chk("blink_idx3_seg", {1'b0, seg}, 8'h7F);
    sel = 1'b1; hold(3);
    chk("blink_sel1_seg", {1'b0, seg}, 8'h40);
    adj = 1'b0; hold(3);
    chk("blink_run_seg", {1'b0, seg}, 8'h40);

    // Mid-operation reset at 12:34 while paused.
    do_reset();
    adj = 1'b1; sel = 1'b0; pulses(1, 12);
    sel = 1'b1; pulses(1, 34);
    adj = 1'b0; pulse(2);
    pulse(4); pulse(0);
    chk("mid_min", min_bcd, 8'h12);
    chk("mid_sec", sec_bcd, 8'h34);
    rst = 1'b1; hold(1); rst = 1'b0;
    chk("mrst_min", min_bcd, 8'h00);
    chk("mrst_sec", sec_bcd, 8'h00);
    chk("mrst_an", {4'h0, an}, 8'h0E);
    chk("mrst_seg", {1'b0, seg}, 8'h40);
    hold(5);
    pulse(0);
    chk("mrst_unpaused", sec_bcd, 8'h01);
    lv[0] = 1'b1; rst = 1'b1; hold(1); rst = 1'b0;
    hold(8);
    chk("held_across_rst", sec_bcd, 8'h00);
    lv[0] = 1'b0; hold(4);
    pulse(0);
    chk("after_held", sec_bcd, 8'h01);

    // Randomized steps against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] nlv;
      nlv = 5'($urandom);
      if ($urandom_range(0, 7) == 0) adj = ~adj;
      if ($urandom_range(0, 3) == 0) sel = ~sel;
      lv = nlv;
      model_apply(nlv, adj, sel);
      hold(5);
      chk($sformatf("rnd%0d_min", i), min_bcd, to_bcd(m_min));
      chk($sformatf("rnd%0d_sec", i), sec_bcd, to_bcd(m_sec));
      chk($sformatf("rnd%0d_an", i), {4'h0, an}, {4'h0, ~(4'b0001 << m_idx)});
      chk($sformatf("rnd%0d_seg", i), {1'b0, seg}, {1'b0, model_seg(adj, sel)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Consumer side of the stopwatch clock-divider outputs. Samples the four divided clock levels (`counter_clk`, `adj_clk`, `disp_clk`, `blink_clk`) in the `clk` domain and turns their rising edges into single-cycle ticks. Uses those ticks to run an mm:ss BCD counter with pause and adjust modes, and drives the 4-digit multiplexed seven-segment display. Sits between the clock divider and the board pins.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per divided-clock input (minimum 2).
- `MAX_MIN`, default 59: highest minutes value before wrap to 0.
- `clk`, in, 1: system clock (100 MHz).
- `rst`, in, 1: reset. **One clock; reset is synchronous and active-high.**
- `counter_clk`, in, 1: 1 Hz divided clock level. Drives run-mode counting.
- `adj_clk`, in, 1: 2 Hz divided clock level. Drives adjust-mode stepping.
- `disp_clk`, in, 1: ~300 Hz divided clock level. Drives digit scan.
- `blink_clk`, in, 1: 4 Hz divided clock level. Drives blink phase.
- `pause_btn`, in, 1: debounced pause button level.
- `adj`, in, 1: 1 selects adjust mode.
- `sel`, in, 1: adjust target; 0 = minutes, 1 = seconds.
- `min_bcd`, out, 8: minutes, {tens, ones}.
- `sec_bcd`, out, 8: seconds, {tens, ones}.
- `an`, out, 4: digit enables, active-low. `an[3]` = minutes tens … `an[0]` = seconds ones.
- `seg`, out, 7: segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- **Tick generation.** Each divided input passes through a `SYNC_STAGES` flop chain. A tick is `sync_last_minus_1 & ~sync_last`: exactly one `clk` cycle per input rising edge.
- **Pause.** A rising edge of synchronized `pause_btn` toggles `paused`.
- **Run mode** (`adj`=0, `!paused`), on counter tick: add 1 s.
  - Seconds 59 → 00 with carry into minutes.
  - `MAX_MIN`:59 → 00:00.
  - Adjust ticks are ignored.
- **Adjust mode** (`adj`=1, `!paused`), on adj tick:
  - `sel`=0: minutes +1, `MAX_MIN` → 0; seconds untouched.
  - `sel`=1: seconds +1, 59 → 0; no carry into minutes.
  - Counter ticks are ignored.
- **While paused:** no digit changes in either mode. Scan and blink keep running.
- **BCD arithmetic.** Ones 9 → 0 with carry to tens; tens never exceeds 5. Digits are always valid BCD.
- **Blink.** `blink_phase` toggles on each blink tick. In adjust mode, when `blink_phase`=0, both digits of the selected pair show all segments off (`seg`=7'h7F) while their `an` slot is still driven. In run mode nothing blinks.
- **Scan.** 2-bit `digit_idx` increments (mod 4) on each disp tick. `an` = one-hot-low of `digit_idx`. `seg` = decode of the indexed digit.
- **Simultaneous events.**
  - Pause edge and count/adj tick in the same cycle: the tick is qualified by the pre-toggle `paused` value.
  - `adj`/`sel` changes take effect on the next cycle's tick qualification. Counters are not cleared.
- **Reset values** (mid-operation reset aborts everything next edge):
  - `min_bcd` = `sec_bcd` = 0
  - `paused` = 0, `blink_phase` = 1, `digit_idx` = 0
  - all synchronizer flops = 0
  - `an` = 4'b1110, `seg` = 7'b1000000 ("0")

## Timing
- Input rising edge first sampled at `clk` edge k → tick high during cycle k+`SYNC_STAGES`-1 → digit register update at edge k+`SYNC_STAGES`.
- `min_bcd`/`sec_bcd` are registered: visible the cycle after the tick.
- `an`/`seg` are registered from `digit_idx` and the digits: one cycle after either changes.
- An input held high produces no further ticks.
- The first input sample after reset does not generate a tick, because sync flops reset to 0 and inputs are low at divider reset.

## Structure
- Package `stopwatch_pkg`:
  - `bcd_t` (4-bit) typedef
  - `SEG_DIGIT[0:9]` constants and `SEG_BLANK` = 7'h7F
  - `NUM_DIGITS` = 4
  - `digit_idx_t` (2-bit)
- Sub-module `sync_edge` (`SYNC_STAGES`; ports `clk`, `rst`, `d`, `rise`), instantiated five times: four divided clocks plus `pause_btn`.
- Core counter, blink and scan logic live in `stopwatch_core`.

## Test plan
- **Run/wrap:** reset, then 60 counter pulses → `sec_bcd`=8'h00, `min_bcd`=8'h01. Preload 59:59, one pulse → 00:00.
- **Pause, coincident edge:** pause edge coincident with a counter tick at 00:05 → counter stays 00:05 through 3 more pulses. Second pause edge resumes; next pulse → 00:06.
- **Adjust:** `adj`=1, `sel`=1 at 00:59, one adj pulse → 00:00 (minutes unchanged). `sel`=0 at 59:00, one pulse → 00:00. Counter pulses ignored throughout.
- **Scan/blink:** 4 disp pulses → `an` cycles 1101, 1011, 0111, 1110. In adjust mode with `sel`=0 and `blink_phase`=0 → `seg`=7'h7F while `an[3]`/`an[2]` are active.
- **Reset mid-operation:** `rst` pulsed at 12:34 with `paused`=1 → next cycle all outputs at reset values. A counter pulse held high across reset release produces no tick.
- **Latency:** `counter_clk` rises one cycle before edge k → `sec_bcd` changes exactly after edge k+2 (`SYNC_STAGES`=2). A pulse held high for 10 cycles increments exactly once.
